// File: rtl/slv_rr_arbiter.sv
// Round-robin arbiter multiplexing NUM_SLV slave streams into one FIFO write port.
// Per-grant burst limit, lossless valid/ready handshake, registered write-side outputs.
module slv_rr_arbiter #(
    parameter int unsigned NUM_SLV   = 4,
    parameter int unsigned DW        = 32,
    parameter int unsigned PW        = 8,
    parameter int unsigned MW        = 2,
    parameter int unsigned BURST_MAX = 16,
    localparam int unsigned SW       = $clog2(NUM_SLV)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SLV*MW-1:0] slv_mode,
    input  logic [NUM_SLV-1:0]    slv_data_valid,
    input  logic [NUM_SLV*DW-1:0] slv_data,
    input  logic [NUM_SLV*PW-1:0] slv_proc_val,
    output logic [NUM_SLV-1:0]    slv_ready,
    input  logic                  fifo_full,
    input  logic                  mstr_cmplt,
    output logic [MW-1:0]         slvx_mode,
    output logic [DW-1:0]         slvx_data,
    output logic [PW-1:0]         slvx_proc_val,
    output logic                  slvx_data_valid,
    output logic [SW-1:0]         data_source,
    output logic                  grant_active
);

    localparam int unsigned CW = $clog2(BURST_MAX + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SW-1:0]       r_grant;
    logic [SW-1:0]       r_last_grant;
    logic [CW-1:0]       r_beat_cnt;
    logic                r_vld;
    logic [MW-1:0]       r_mode;
    logic [DW-1:0]       r_data;
    logic [PW-1:0]       r_pval;
    logic [SW-1:0]       r_src;

    logic [NUM_SLV-1:0]  w_req;
    logic [MW-1:0]       w_mode [NUM_SLV];
    logic [DW-1:0]       w_data [NUM_SLV];
    logic [PW-1:0]       w_pval [NUM_SLV];
    logic [NUM_SLV-1:0]  w_ready;
    logic                w_xfer;
    logic                w_pick_vld;
    logic [SW-1:0]       w_pick;

    // Unpack the per-slave buses and derive request flags.
    always_comb begin
        for (int i = 0; i < NUM_SLV; i++) begin
            w_mode[i] = slv_mode[i*MW +: MW];
            w_data[i] = slv_data[i*DW +: DW];
            w_pval[i] = slv_proc_val[i*PW +: PW];
            w_req[i]  = (w_mode[i] != '0);
        end
    end

    // Descending scan so the nearest requester after last_grant wins.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick     = '0;
        for (int k = NUM_SLV; k >= 1; k--) begin
            int idx;
            idx = (int'(r_last_grant) + k) % NUM_SLV;
            if (w_req[idx]) begin
                w_pick_vld = 1'b1;
                w_pick     = SW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_xfer      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!mstr_cmplt && w_pick_vld) begin
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                w_ready[r_grant] = ~fifo_full & ~mstr_cmplt;
                w_xfer           = w_ready[r_grant] & slv_data_valid[r_grant];
                if (!w_req[r_grant] || mstr_cmplt ||
                    (w_xfer && (r_beat_cnt == CW'(BURST_MAX - 1)))) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Grant bookkeeping and the registered write-side beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant      <= '0;
            r_last_grant <= SW'(NUM_SLV - 1);
            r_beat_cnt   <= '0;
            r_vld        <= 1'b0;
            r_mode       <= '0;
            r_data       <= '0;
            r_pval       <= '0;
            r_src        <= '0;
        end else begin
            r_vld <= w_xfer;
            if (w_xfer) begin
                r_mode <= w_mode[r_grant];
                r_data <= w_data[r_grant];
                r_pval <= w_pval[r_grant];
                r_src  <= r_grant;
            end
            if (r_state == S_IDLE && w_state_nxt == S_GRANT) begin
                r_grant      <= w_pick;
                r_last_grant <= w_pick;
                r_beat_cnt   <= '0;
            end else if (w_xfer) begin
                r_beat_cnt <= r_beat_cnt + CW'(1);
            end
        end
    end

    assign slv_ready       = w_ready;
    assign slvx_data_valid = r_vld;
    assign slvx_mode       = r_mode;
    assign slvx_data       = r_data;
    assign slvx_proc_val   = r_pval;
    assign data_source     = r_src;
    assign grant_active    = (r_state == S_GRANT);

endmodule

// File: tb/tb_slv_rr_arbiter.sv
// Scoreboard bench for slv_rr_arbiter: a per-cycle behavioural model predicts ready and
// accepted beats; a negedge monitor pops and compares every FIFO write strobe.
module tb_slv_rr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned PW = 8;
    localparam int unsigned MW = 2;
    localparam int unsigned BM = 4;
    localparam int unsigned SW = 2;

    logic              clk;
    logic              rst_n;
    logic [N*MW-1:0]   slv_mode;
    logic [N-1:0]      slv_data_valid;
    logic [N*DW-1:0]   slv_data;
    logic [N*PW-1:0]   slv_proc_val;
    logic [N-1:0]      slv_ready;
    logic              fifo_full;
    logic              mstr_cmplt;
    logic [MW-1:0]     slvx_mode;
    logic [DW-1:0]     slvx_data;
    logic [PW-1:0]     slvx_proc_val;
    logic              slvx_data_valid;
    logic [SW-1:0]     data_source;
    logic              grant_active;

    slv_rr_arbiter #(
        .NUM_SLV(N), .DW(DW), .PW(PW), .MW(MW), .BURST_MAX(BM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .slv_mode(slv_mode), .slv_data_valid(slv_data_valid),
        .slv_data(slv_data), .slv_proc_val(slv_proc_val), .slv_ready(slv_ready),
        .fifo_full(fifo_full), .mstr_cmplt(mstr_cmplt), .slvx_mode(slvx_mode),
        .slvx_data(slvx_data), .slvx_proc_val(slvx_proc_val),
        .slvx_data_valid(slvx_data_valid), .data_source(data_source),
        .grant_active(grant_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            src;
        logic [MW-1:0] mode;
        logic [DW-1:0] data;
        logic [PW-1:0] pval;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       last_b;
    int          obs_src[$];
    logic [DW-1:0] obs_data[$];
    int          total = 0;
    int          bad   = 0;
    bit          mon_en = 0;
    logic [N-1:0] dut_hs;

    // Reference model: owner (-1 = nobody holds the grant), last owner, beats in grant.
    int m_owner;
    int m_last;
    int m_beats;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_beats = 0;
    endtask

    function automatic logic [MW-1:0] mode_of(input int i);
        logic [N*MW-1:0] v;
        v = slv_mode;
        return v[i*MW +: MW];
    endfunction

    task automatic model_step();
        logic [N-1:0] exp_rdy;
        bit           acc;
        bit           found;
        int           c;
        beat_t        b;
        logic [N*DW-1:0] dv;
        logic [N*PW-1:0] pv;
        exp_rdy = '0;
        if (m_owner >= 0 && !fifo_full && !mstr_cmplt) exp_rdy[m_owner] = 1'b1;
        chk("slv_ready", 64'(slv_ready), 64'(exp_rdy));
        chk("grant_active", 64'(grant_active), 64'(m_owner >= 0));
        if (m_owner < 0) begin
            found = 0;
            if (!mstr_cmplt) begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (!found && mode_of(c) != 0) begin
                        found   = 1;
                        m_owner = c;
                        m_last  = c;
                        m_beats = 0;
                    end
                end
            end
        end else begin
            acc = exp_rdy[m_owner] && slv_data_valid[m_owner];
            if (acc) begin
                dv     = slv_data;
                pv     = slv_proc_val;
                b.src  = m_owner;
                b.mode = mode_of(m_owner);
                b.data = dv[m_owner*DW +: DW];
                b.pval = pv[m_owner*PW +: PW];
                exp_q.push_back(b);
                m_beats++;
            end
            if (mode_of(m_owner) == 0 || mstr_cmplt || (acc && m_beats == BM)) m_owner = -1;
        end
    endtask

    // One clock cycle: inputs were set just after the previous edge.
    task automatic cycle();
        #3;
        dut_hs = slv_ready & slv_data_valid;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs();
        chk("rst_slv_ready", 64'(slv_ready), 64'd0);
        chk("rst_valid", 64'(slvx_data_valid), 64'd0);
        chk("rst_mode", 64'(slvx_mode), 64'd0);
        chk("rst_data", 64'(slvx_data), 64'd0);
        chk("rst_pval", 64'(slvx_proc_val), 64'd0);
        chk("rst_src", 64'(data_source), 64'd0);
        chk("rst_grant_active", 64'(grant_active), 64'd0);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        #1;
        chk_zero_outputs();
        model_reset();
        exp_q.delete();
        last_b = '{src: 0, mode: '0, data: '0, pval: '0};
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_slave(input int i, input logic [MW-1:0] m, input logic v,
                             input logic [DW-1:0] d);
        slv_mode[i*MW +: MW]     = m;
        slv_data_valid[i]        = v;
        slv_data[i*DW +: DW]     = d;
        slv_proc_val[i*PW +: PW] = PW'($urandom);
    endtask

    task automatic all_quiet();
        slv_mode       = '0;
        slv_data_valid = '0;
        fifo_full      = 1'b0;
        mstr_cmplt     = 1'b0;
    endtask

    task automatic mon_check();
        beat_t b;
        if (slvx_data_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat actual_src=%0d actual_data=%0h required=no beat",
                         data_source, slvx_data);
            end else begin
                b = exp_q.pop_front();
                chk("beat_src", 64'(data_source), 64'(b.src));
                chk("beat_mode", 64'(slvx_mode), 64'(b.mode));
                chk("beat_data", 64'(slvx_data), 64'(b.data));
                chk("beat_pval", 64'(slvx_proc_val), 64'(b.pval));
                last_b = b;
            end
            obs_src.push_back(int'(data_source));
            obs_data.push_back(slvx_data);
        end else begin
            chk("hold_src", 64'(data_source), 64'(last_b.src));
            chk("hold_mode", 64'(slvx_mode), 64'(last_b.mode));
            chk("hold_data", 64'(slvx_data), 64'(last_b.data));
            chk("hold_pval", 64'(slvx_proc_val), 64'(last_b.pval));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) mon_check();
        end
    end

    initial begin
        int sent;
        int full_left;
        int s0_beats;
        rst_n          = 1'b0;
        slv_data       = '0;
        slv_proc_val   = '0;
        all_quiet();
        @(posedge clk);
        #1;
        reset_dut();
        mon_en = 1;

        // Idle with all modes zero.
        repeat (20) cycle();

        // Slaves 1 and 3 always valid: alternating 4-beat grants.
        obs_src.delete();
        obs_data.delete();
        for (int c = 0; c < 40; c++) begin
            all_quiet();
            set_slave(1, 2'd1, 1'b1, DW'($urandom));
            set_slave(3, 2'd2, 1'b1, DW'($urandom));
            cycle();
        end
        all_quiet();
        repeat (3) cycle();
        chk("alt_beat_count", 64'(obs_src.size()), 64'd32);
        for (int j = 0; j < obs_src.size() && j < 32; j++)
            chk("alt_src_order", 64'(obs_src[j]), ((j / 4) % 2 == 0) ? 64'd1 : 64'd3);

        // Slave 2 streams A0..A5, FIFO full for 3 cycles after the 2nd beat.
        obs_src.delete();
        obs_data.delete();
        sent      = 0;
        full_left = 3;
        for (int c = 0; c < 40 && sent < 6; c++) begin
            all_quiet();
            set_slave(2, 2'd1, sent < 6, DW'(32'hA0 + sent));
            fifo_full = (sent >= 2 && full_left > 0);
            cycle();
            if (fifo_full) full_left--;
            if (dut_hs[2]) sent++;
        end
        chk("stream_sent", 64'(sent), 64'd6);
        all_quiet();
        repeat (3) cycle();
        chk("stream_count", 64'(obs_data.size()), 64'd6);
        for (int j = 0; j < obs_data.size() && j < 6; j++)
            chk("stream_data", 64'(obs_data[j]), 64'(32'hA0 + j));

        // mstr_cmplt while slave 0 holds the grant; rotation resumes at slave 1.
        obs_src.delete();
        for (int c = 0; c < 20; c++) begin
            all_quiet();
            set_slave(0, 2'd1, 1'b1, DW'($urandom));
            set_slave(1, 2'd3, 1'b1, DW'($urandom));
            mstr_cmplt = (c >= 3 && c <= 6);
            cycle();
        end
        all_quiet();
        repeat (3) cycle();
        chk("mc_beats", 64'(obs_src.size() >= 3), 64'd1);
        if (obs_src.size() >= 3) begin
            chk("mc_src0", 64'(obs_src[0]), 64'd0);
            chk("mc_src1", 64'(obs_src[1]), 64'd0);
            chk("mc_resume", 64'(obs_src[2]), 64'd1);
        end

        // Reset mid-burst, then arbitration restarts from slave 0.
        for (int c = 0; c < 3; c++) begin
            all_quiet();
            set_slave(2, 2'd1, 1'b1, DW'($urandom));
            cycle();
        end
        reset_dut();
        obs_src.delete();
        for (int c = 0; c < 6; c++) begin
            all_quiet();
            for (int i = 0; i < N; i++) set_slave(i, 2'd1, 1'b1, DW'($urandom));
            cycle();
        end
        all_quiet();
        repeat (3) cycle();
        chk("post_rst_first_src", (obs_src.size() > 0) ? 64'(obs_src[0]) : 64'hdead, 64'd0);

        // Slave 0 drops its mode after 2 beats while slave 1 waits.
        reset_dut();
        obs_src.delete();
        s0_beats = 0;
        for (int c = 0; c < 15; c++) begin
            all_quiet();
            set_slave(0, (s0_beats < 2) ? 2'd1 : 2'd0, s0_beats < 2, DW'($urandom));
            set_slave(1, 2'd2, 1'b1, DW'($urandom));
            cycle();
            if (dut_hs[0]) s0_beats++;
        end
        all_quiet();
        repeat (3) cycle();
        chk("drop_s0_beats", 64'(s0_beats), 64'd2);
        if (obs_src.size() >= 3) chk("drop_next_src", 64'(obs_src[2]), 64'd1);
        else chk("drop_beat_count", 64'(obs_src.size()), 64'd3);

        // Random traffic: mode changes, valid gaps, backpressure, master complete.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) slv_mode[i*MW +: MW] = MW'($urandom);
                slv_data_valid[i]        = ($urandom_range(3) != 0);
                slv_data[i*DW +: DW]     = DW'($urandom);
                slv_proc_val[i*PW +: PW] = PW'($urandom);
            end
            fifo_full  = ($urandom_range(4) == 0);
            mstr_cmplt = ($urandom_range(24) == 0);
            cycle();
        end
        all_quiet();
        repeat (4) cycle();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
